// File: rtl/lsu_pkg.sv
// Shared encodings and constants for the load/store unit and its alignment helper.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable generation, legality check for new requests,
// and extraction/extension of load data from the returned memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic        req_we_i,
  output logic [3:0]  bytes_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rd_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    bytes_o   = '0;
    illegal_o = 1'b0;
    case (req_size_i)
      SZ_B:  bytes_o = 4'b0001 << req_off_i;
      SZ_BU: begin
        bytes_o   = 4'b0001 << req_off_i;
        illegal_o = req_we_i;
      end
      SZ_H:  begin
        bytes_o   = 4'b0011 << req_off_i;
        illegal_o = req_off_i[0];
      end
      SZ_HU: begin
        bytes_o   = 4'b0011 << req_off_i;
        illegal_o = req_off_i[0] | req_we_i;
      end
      SZ_W:  begin
        bytes_o   = '1;
        illegal_o = (req_off_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    shifted = rd_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      SZ_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      SZ_BU:   ld_data_o = {24'h0, shifted[7:0]};
      SZ_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      SZ_HU:   ld_data_o = {16'h0, shifted[15:0]};
      SZ_W:    ld_data_o = shifted;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one core access onto a GNT/VALID memory port,
// with request latching, response capture and a wait-cycle timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [2:0]  LSU_SIZE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WD,
  output logic [31:0] LSU_RD,
  output logic        LSU_STALL,
  output logic        LSU_ERR,
  output logic        REQ,
  input  logic        GNT,
  input  logic        ERR,
  input  logic        VALID,
  output logic        WE,
  output logic [3:0]  Bytes,
  output logic [31:0] AD,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  bytes_q, bytes_d;
  logic [31:0] ad_q, ad_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  bytes_new;
  logic        illegal;
  logic [31:0] ld_data;

  lsu_align u_align (
    .req_size_i (LSU_SIZE),
    .req_off_i  (LSU_ADDR[1:0]),
    .req_we_i   (LSU_WE),
    .bytes_o    (bytes_new),
    .illegal_o  (illegal),
    .ld_size_i  (size_q),
    .ld_off_i   (ad_q[1:0]),
    .rd_i       (RD),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      we_q    <= 1'b0;
      bytes_q <= '0;
      ad_q    <= '0;
      wd_q    <= '0;
      size_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      bytes_q <= bytes_d;
      ad_q    <= ad_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // REQ and RSP share one arm: ERR beats completion, which beats timeout.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    bytes_d = bytes_q;
    ad_d    = ad_q;
    wd_d    = wd_q;
    size_d  = size_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (LSU_REQ) begin
          if (illegal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rd_d    = '0;
          end else begin
            state_d = S_REQ;
            we_d    = LSU_WE;
            bytes_d = bytes_new;
            ad_d    = LSU_ADDR;
            wd_d    = LSU_WD;
            size_d  = LSU_SIZE;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_REQ, S_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (ERR) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rd_d    = '0;
        end else if (VALID && (state_q == S_RSP || GNT)) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          rd_d    = we_q ? '0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rd_d    = '0;
        end else if (GNT && state_q == S_REQ) begin
          state_d = S_RSP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rd_d    = '0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    REQ       = (state_q == S_REQ);
    LSU_STALL = LSU_REQ && (state_q != S_DONE);
    LSU_ERR   = (state_q == S_DONE) && err_q;
    LSU_RD    = rd_q;
    WE        = we_q;
    Bytes     = bytes_q;
    AD        = ad_q;
    WD        = wd_q;
  end

endmodule
